load_store_unit: RTL and testbench

- Multi-cycle bridge between the single-cycle core's memory stage and an external word-wide memory bus with wait states.
- Consumes the core's ALU address, store data and width code; produces byte-aligned bus transactions and sign/zero-extended load data.
- Stalls the core until the access completes.
- Detects misaligned or illegal accesses and bus timeouts.

---
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Bridges the core memory stage to a wait-stated word bus: lane steering, load extension, fault detection.
// Latency: request cycle + >=1 BUSY cycle + DONE; stall is held until DONE, bus_req is held until ack or timeout.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  mem_width,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned_fault,
    output logic        bus_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    state_e      state_q;
    logic [2:0]  width_q;
    logic [1:0]  lo_q;
    logic [15:0] cnt_q;
    logic        bus_req_q, bus_we_q, mis_q, bfault_q;
    logic [31:0] bus_addr_q, bus_wdata_q, load_data_q;
    logic [3:0]  bus_be_q;

    logic        legal_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, lane_d, ext_d;

    always_comb begin
        legal_d = 1'b0;
        case (mem_width)
            3'b000:  legal_d = 1'b1;
            3'b001:  legal_d = ~addr[0];
            3'b010:  legal_d = (addr[1:0] == 2'b00);
            3'b100:  legal_d = ~req_write;
            3'b101:  legal_d = ~req_write & ~addr[0];
            default: legal_d = 1'b0;
        endcase
    end

    always_comb begin
        be_d    = 4'hF;
        wdata_d = write_data;
        case (mem_width[1:0])
            2'b00: begin
                if (req_write) be_d = 4'b0001 << addr[1:0];
                wdata_d = {4{write_data[7:0]}};
            end
            2'b01: begin
                if (req_write) be_d = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Loads always fetch the whole word; the addressed lane is shifted down to bit 0.
    always_comb begin
        lane_d = bus_rdata >> {lo_q, 3'b000};
        case (width_q)
            3'b000:  ext_d = {{24{lane_d[7]}}, lane_d[7:0]};
            3'b001:  ext_d = {{16{lane_d[15]}}, lane_d[15:0]};
            3'b100:  ext_d = {24'd0, lane_d[7:0]};
            3'b101:  ext_d = {16'd0, lane_d[15:0]};
            default: ext_d = lane_d;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            width_q     <= 3'd0;
            lo_q        <= 2'd0;
            cnt_q       <= 16'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            load_data_q <= 32'd0;
            mis_q       <= 1'b0;
            bfault_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    mis_q    <= 1'b0;
                    bfault_q <= 1'b0;
                    if (req_valid) begin
                        if (legal_d) begin
                            width_q     <= mem_width;
                            lo_q        <= addr[1:0];
                            bus_addr_q  <= {addr[31:2], 2'b00};
                            bus_be_q    <= be_d;
                            bus_wdata_q <= wdata_d;
                            bus_we_q    <= req_write;
                            bus_req_q   <= 1'b1;
                            cnt_q       <= 16'd0;
                            state_q     <= S_BUSY;
                        end else begin
                            mis_q       <= 1'b1;
                            load_data_q <= 32'd0;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    // An ack on the final permitted cycle still wins over the timeout.
                    if (bus_ack) begin
                        load_data_q <= ext_d;
                        bus_req_q   <= 1'b0;
                        state_q     <= S_DONE;
                    end else if (cnt_q == TMO) begin
                        bfault_q    <= 1'b1;
                        load_data_q <= 32'd0;
                        bus_req_q   <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DONE: begin
                    mis_q    <= 1'b0;
                    bfault_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Gating with reset lets an abandoned access release the core immediately.
    assign stall            = reset & req_valid & (state_q != S_DONE);
    assign load_data        = load_data_q;
    assign misaligned_fault = mis_q;
    assign bus_fault        = bfault_q;
    assign bus_req          = bus_req_q;
    assign bus_we           = bus_we_q;
    assign bus_addr         = bus_addr_q;
    assign bus_be           = bus_be_q;
    assign bus_wdata        = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a small core/bus driver.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write;
    logic [2:0]  mem_width;
    logic [31:0] addr, write_data;
    logic        stall;
    logic [31:0] load_data;
    logic        misaligned_fault, bus_fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_write(req_write), .mem_width(mem_width),
        .addr(addr), .write_data(write_data),
        .stall(stall), .load_data(load_data),
        .misaligned_fault(misaligned_fault), .bus_fault(bus_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  wid;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          wait_n;   // BUSY cycles before ack; -1 = never
        logic [3:0]  be;
        logic [31:0] exp_wd;
        logic [31:0] ba;
        logic [31:0] ld;
        logic        mis;
        logic        bf;
        int          stall_n;
        int          req_n;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_access(input vec_t v, input int idx);
        int busy_n = 0, stall_n = 0, req_n = 0, mis_n = 0, bf_n = 0;
        logic done = 1'b0, got = 1'b0, unstable = 1'b0;
        logic [31:0] cap_addr = 32'd0, cap_wd = 32'd0;
        logic [3:0]  cap_be = 4'd0;
        logic        cap_we = 1'b0;
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        req_valid = 1'b1; req_write = v.wr; mem_width = v.wid;
        addr = v.a; write_data = v.wd; bus_ack = 1'b0; bus_rdata = 32'h5A5A5A5A;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (bus_req) begin
                if (!got) begin
                    got = 1'b1; cap_addr = bus_addr; cap_be = bus_be;
                    cap_wd = bus_wdata; cap_we = bus_we;
                end else if (bus_addr !== cap_addr || bus_be !== cap_be ||
                             bus_wdata !== cap_wd || bus_we !== cap_we) begin
                    unstable = 1'b1;
                end
                bus_ack   = (v.wait_n >= 0 && busy_n == v.wait_n);
                bus_rdata = bus_ack ? v.rd : 32'h5A5A5A5A;
                busy_n++;
                addr = ~v.a; write_data = ~v.wd; mem_width = 3'b111; req_write = ~v.wr;
            end else begin
                bus_ack = 1'b0;
            end
            #1;
            stall_n += int'(stall); req_n += int'(bus_req);
            mis_n += int'(misaligned_fault); bf_n += int'(bus_fault);
            if (!stall) done = 1'b1;
            else @(negedge clk);
        end
        chk({p, " completes"}, 32'(done), 32'd1);
        chk({p, " load_data"}, load_data, v.ld);
        chk({p, " misaligned in DONE"}, 32'(misaligned_fault), 32'(v.mis));
        chk({p, " bus_fault in DONE"}, 32'(bus_fault), 32'(v.bf));
        chk({p, " stall cycles"}, 32'(stall_n), 32'(v.stall_n));
        chk({p, " bus_req cycles"}, 32'(req_n), 32'(v.req_n));
        @(negedge clk);
        req_valid = 1'b0; bus_ack = 1'b0;
        #1;
        mis_n += int'(misaligned_fault); bf_n += int'(bus_fault);
        chk({p, " misaligned pulse count"}, 32'(mis_n), 32'(v.mis));
        chk({p, " bus_fault pulse count"}, 32'(bf_n), 32'(v.bf));
        chk({p, " idle bus_req"}, 32'(bus_req), 32'd0);
        if (v.req_n > 0) begin
            chk({p, " bus_addr"}, cap_addr, v.ba);
            chk({p, " bus_be"}, 32'(cap_be), 32'(v.be));
            chk({p, " bus_wdata"}, cap_wd, v.exp_wd);
            chk({p, " bus_we"}, 32'(cap_we), 32'(v.wr));
            chk({p, " bus stable"}, 32'(unstable), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t extra;
        //           wr    wid     addr       wdata          rdata        wait be     exp_wd         bus_addr   load_data     mis   bf   st rq
        vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        2,  4'hF, 32'hDEADBEEF, 32'h100, 32'h0,        1'b0, 1'b0, 4, 3};
        vecs[1]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0,  4'h8, 32'hA5A5A5A5, 32'h100, 32'h0,        1'b0, 1'b0, 2, 1};
        vecs[2]  = '{1'b0, 3'b000, 32'h102, 32'h0,        32'h12805634, 0,  4'hF, 32'h0,        32'h100, 32'hFFFFFF80, 1'b0, 1'b0, 2, 1};
        vecs[3]  = '{1'b0, 3'b100, 32'h102, 32'h0,        32'h12805634, 0,  4'hF, 32'h0,        32'h100, 32'h00000080, 1'b0, 1'b0, 2, 1};
        vecs[4]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h12805634, 0,  4'hF, 32'h0,        32'h100, 32'h00001280, 1'b0, 1'b0, 2, 1};
        vecs[5]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80015634, 0,  4'hF, 32'h0,        32'h100, 32'hFFFF8001, 1'b0, 1'b0, 2, 1};
        vecs[6]  = '{1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, 1,  4'hF, 32'h0,        32'h104, 32'hCAFEF00D, 1'b0, 1'b0, 3, 2};
        vecs[7]  = '{1'b0, 3'b010, 32'h106, 32'h0,        32'h0,        0,  4'hF, 32'h0,        32'h0,   32'h0,        1'b1, 1'b0, 1, 0};
        vecs[8]  = '{1'b1, 3'b001, 32'h101, 32'h1234,     32'h0,        0,  4'hF, 32'h0,        32'h0,   32'h0,        1'b1, 1'b0, 1, 0};
        vecs[9]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h0000FF00, 0,  4'hF, 32'h0,        32'h100, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 1};
        vecs[10] = '{1'b1, 3'b100, 32'h0,   32'h0,        32'h0,        0,  4'hF, 32'h0,        32'h0,   32'h0,        1'b1, 1'b0, 1, 0};
        vecs[11] = '{1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        1,  4'hC, 32'hABCDABCD, 32'h100, 32'h0,        1'b0, 1'b0, 3, 2};
        vecs[12] = '{1'b1, 3'b000, 32'h101, 32'h00000077, 32'h0,        0,  4'h2, 32'h77777777, 32'h100, 32'h0,        1'b0, 1'b0, 2, 1};
        vecs[13] = '{1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        0,  4'hF, 32'h0,        32'h0,   32'h0,        1'b1, 1'b0, 1, 0};
        vecs[14] = '{1'b0, 3'b010, 32'h300, 32'h0,        32'h13579BDF, 4,  4'hF, 32'h0,        32'h300, 32'h13579BDF, 1'b0, 1'b0, 6, 5};
        vecs[15] = '{1'b0, 3'b010, 32'h200, 32'h0,        32'h0,        -1, 4'hF, 32'h0,        32'h200, 32'h0,        1'b0, 1'b1, 6, 5};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; mem_width = 3'b000;
        addr = 32'd0; write_data = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset bus_req", 32'(bus_req), 32'd0);
        chk("reset bus_we", 32'(bus_we), 32'd0);
        chk("reset bus_be", 32'(bus_be), 32'd0);
        chk("reset bus_addr", bus_addr, 32'd0);
        chk("reset bus_wdata", bus_wdata, 32'd0);
        chk("reset load_data", load_data, 32'd0);
        chk("reset faults", {30'd0, misaligned_fault, bus_fault}, 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_access(vecs[i], i);

        // Spurious ack while idle must not disturb captured load data.
        extra = '{1'b0, 3'b010, 32'h0, 32'h0, 32'h0BADF00D, 0, 4'hF, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 1'b0, 2, 1};
        run_access(extra, 16);
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("spurious ack bus_req", 32'(bus_req), 32'd0);
        chk("spurious ack load_data", load_data, 32'h0BADF00D);
        chk("spurious ack faults", {30'd0, misaligned_fault, bus_fault}, 32'd0);
        @(negedge clk);
        #1;
        chk("spurious ack still idle", 32'(bus_req), 32'd0);

        // Reset in the middle of a bus access.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; mem_width = 3'b010; addr = 32'h400;
        repeat (2) @(negedge clk);
        #1;
        chk("mid-busy bus_req before reset", 32'(bus_req), 32'd1);
        chk("mid-busy stall before reset", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset bus_req", 32'(bus_req), 32'd0);
        chk("async reset stall", 32'(stall), 32'd0);
        chk("async reset load_data", load_data, 32'd0);
        @(negedge clk);
        req_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post reset idle bus_req", 32'(bus_req), 32'd0);
        chk("post reset idle stall", 32'(stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
